ma_burst_scheduler: RTL and testbench
=====================================

# ma_burst_scheduler

Round-robin scheduler that shares one moving-average filter datapath among `NUM_REQ` sample requesters. It grants the filter to one requester per burst and clears the filter at the start of each burst. It streams the owner's samples into the filter with a valid/ready handshake and flags results only once the window is full, tagged with the owner id. The block sits between the sensor-side requesters and the filter, and it alone drives the filter's clear and load controls.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `SAMPLE_W`, 6, packed sample width ({t,y,x}, 2 bits each)
- `WINDOW_SIZE`, 4, filter window depth; result is valid after this many loads
- `MAX_BURST`, 16, sample limit per grant (only with `MA_SCHED_TIMEOUT_EN`)

Ports:
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `req` in NUM_REQ: requester wants the filter; held for the whole burst
- `in_valid` in NUM_REQ: per-requester sample valid
- `in_last` in NUM_REQ: marks the final sample of a burst, qualified by handshake
- `in_data` in NUM_REQ*SAMPLE_W: flattened samples; requester i uses bits [i*SAMPLE_W +: SAMPLE_W]
- `in_ready` out NUM_REQ: one-hot to the owner during STREAM, otherwise 0
- `grant` out NUM_REQ: one-hot owner, registered; 0 in IDLE
- `filt_clr` out 1: one-cycle filter clear pulse
- `filt_load` out 1: filter shifts in `filt_data` this cycle
- `filt_data` out SAMPLE_W: sample presented to the filter
- `res_valid` out 1: filter sum is a full-window result this cycle
- `res_id` out clog2(NUM_REQ): owner of the current result
- `busy` out 1: state is not IDLE

## Operation
States are IDLE, CLEAR, STREAM and DRAIN.
- IDLE: if any `req` bit is high, the round-robin arbiter picks the first requester at or after `rr_ptr`.
  - `grant` and the owner id are registered, and the state moves to CLEAR.
- CLEAR: `filt_clr`=1 for exactly one cycle; `fill_cnt` and `burst_cnt` are set to 0; the state moves to STREAM.
- STREAM: `in_ready[owner]`=1. A handshake is `in_valid[owner] & in_ready[owner]`.
  - On each handshake, the sample is registered into `filt_data`, `filt_load` pulses, `fill_cnt` increments (saturating at WINDOW_SIZE), and `burst_cnt` increments.
- Leaving STREAM for DRAIN happens on any of:
  - handshake with `in_last[owner]`;
  - `req[owner]` low (a sample in the same cycle is still accepted);
  - `burst_cnt` reaching MAX_BURST when the timeout is enabled.
  - Several exit causes in the same cycle produce a single transition.
- DRAIN: lasts 2 cycles, so the final load and its result flush out.
  - `in_ready` is 0.
  - `rr_ptr` is set to (owner+1) mod NUM_REQ, then the state returns to IDLE.
- Requests from non-owners are ignored until IDLE. `in_valid` without `in_ready` has no effect.
- `res_valid` is asserted for a load only when `fill_cnt` after that load equals WINDOW_SIZE. Partial-window sums are never flagged.
- `res_id` holds the owner id from grant until the next grant.

## Timing
- Reset values: `grant`=0, `in_ready`=0, `filt_clr`=0, `filt_load`=0, `filt_data`=0, `res_valid`=0, `res_id`=0, `busy`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-burst aborts the burst in that cycle. No `filt_clr` is issued; the next burst's CLEAR cleans the filter.
- `req` seen in IDLE at cycle n gives: `grant` and `busy` at n+1 (CLEAR, `filt_clr`=1), then `in_ready` at n+2.
- A handshake at cycle m gives `filt_load`/`filt_data` at m+1. The filter sum updates on the edge ending m+1, and `res_valid` follows at m+2.
- Throughput is one sample per cycle in STREAM.
- Minimum turnaround from IDLE back to IDLE is 1 (IDLE) + 1 (CLEAR) + 1 (STREAM) + 2 (DRAIN) = 5 cycles.
- All outputs are registered except `in_ready`, which is decoded from the state and owner registers.

## Configuration
- `MA_SCHED_TIMEOUT_EN` defined: a burst is preempted once `burst_cnt` reaches MAX_BURST, and the next requester gets the filter. This guarantees fairness under continuous streaming.
- Not defined: `burst_cnt` and the MAX_BURST parameter logic are absent. A burst ends only on `in_last` or a dropped `req`.

## Structure
- Package `ma_sched_pkg` holds:
  - the state enum (IDLE/CLEAR/STREAM/DRAIN);
  - `SAMPLE_W` and `WINDOW_SIZE` defaults shared with the filter;
  - the id-width constant derived from NUM_REQ.
- Sub-module `rr_arbiter`: combinational round-robin pick with inputs req and ptr, and outputs a one-hot grant plus the index.

## Test plan
- Single requester: `req[1]` with 6 samples 0x01..0x06, last on the 6th.
  - Expect `filt_clr` once, 6 `filt_load` pulses, and `res_valid` on loads 4, 5 and 6 only, each with `res_id`=1.
- Round-robin: all 4 `req` held, each sending 4 samples then last.
  - Expect grant order 0,1,2,3,0, with 5 cycles IDLE-to-IDLE overhead per burst.
- Early drop: `req[2]` deasserted after 2 samples.
  - Expect DRAIN, no `res_valid`, and `rr_ptr`=3.
- Timeout (macro on, MAX_BURST=16): `req[0]` and `req[3]` both streaming.
  - Expect the owner-0 burst to end after the 16th handshake, then `grant`=0b1000.
- Reset asserted in STREAM after 3 samples.
  - Expect all outputs 0 the next cycle; a subsequent `req[0]` gets `grant`=0b0001 with a fresh `filt_clr`.
- Backpressure gaps: `in_valid` toggling 1,0,1,0 on the owner.
  - Expect `filt_load` only after valid cycles and `fill_cnt` counting only handshakes.

Source files
------------

// File: rtl/ma_sched_pkg.sv
// Shared types and defaults for the moving-average burst scheduler.
// Holds the FSM state enum, filter defaults and the requester-id width helper.
package ma_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int SAMPLE_W_DEF    = 6;
    localparam int WINDOW_SIZE_DEF = 4;
    localparam int NUM_REQ_DEF     = 4;

    // A one-bit id is still needed for two requesters, so never return zero.
    function automatic int idWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W_DEF = idWidth(NUM_REQ_DEF);

endpackage

// File: rtl/ma_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr wins.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/ma_burst_scheduler.sv
// Round-robin burst scheduler feeding a shared moving-average filter.
// Optional burst preemption is compiled in with MA_SCHED_TIMEOUT_EN.
module ma_burst_scheduler
    import ma_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int MAX_BURST   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_in_valid,
    input  logic [NUM_REQ-1:0]            i_in_last,
    input  logic [NUM_REQ*SAMPLE_W-1:0]   i_in_data,
    output logic [NUM_REQ-1:0]            o_in_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_filt_clr,
    output logic                          o_filt_load,
    output logic [SAMPLE_W-1:0]           o_filt_data,
    output logic                          o_res_valid,
    output logic [idWidth(NUM_REQ)-1:0]   o_res_id,
    output logic                          o_busy
);

    localparam int ID_W   = idWidth(NUM_REQ);
    localparam int FILL_W = $clog2(WINDOW_SIZE + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || WINDOW_SIZE < 1 || MAX_BURST < 1) begin : gParamCheck
        $error("ma_burst_scheduler: unsupported parameter value");
    end

    state_t              r_state;
    logic                r_drainLast;
    logic [NUM_REQ-1:0]  r_grant;
    logic [ID_W-1:0]     r_ownerId;
    logic [ID_W-1:0]     r_rrPtr;
    logic [FILL_W-1:0]   r_fillCnt;
    logic                r_filtClr;
    logic                r_filtLoad;
    logic [SAMPLE_W-1:0] r_filtData;
    logic                r_resValid;
    logic [ID_W-1:0]     r_resId;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_arbGrant;
    logic [ID_W-1:0]     w_arbIdx;
    logic                w_arbValid;
    logic                w_hs;
    logic                w_ownerReq;
    logic                w_ownerLast;
    logic [SAMPLE_W-1:0] w_ownerData;
    logic                w_timeout;
    logic                w_exit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uArb (
        .i_req   (i_req),
        .i_ptr   (r_rrPtr),
        .o_grant (w_arbGrant),
        .o_idx   (w_arbIdx),
        .o_valid (w_arbValid)
    );

    assign o_in_ready  = (r_state == S_STREAM) ? r_grant : '0;
    assign w_hs        = |(i_in_valid & o_in_ready);
    assign w_ownerReq  = i_req[r_ownerId];
    assign w_ownerLast = i_in_last[r_ownerId];
    assign w_ownerData = i_in_data[r_ownerId*SAMPLE_W +: SAMPLE_W];

`ifdef MA_SCHED_TIMEOUT_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] r_burstCnt;

    // The handshake that brings the count up to the limit is the last one accepted.
    assign w_timeout = w_hs && (r_burstCnt == BURST_W'(MAX_BURST - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_burstCnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_burstCnt <= '0;
        end else if (r_state == S_STREAM && w_hs) begin
            r_burstCnt <= r_burstCnt + BURST_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_exit = (w_hs && w_ownerLast) || !w_ownerReq || w_timeout;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_drainLast <= 1'b0;
            r_grant     <= '0;
            r_ownerId   <= '0;
            r_rrPtr     <= '0;
            r_fillCnt   <= '0;
            r_filtClr   <= 1'b0;
            r_filtLoad  <= 1'b0;
            r_filtData  <= '0;
            r_resValid  <= 1'b0;
            r_resId     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_filtClr  <= 1'b0;
            r_filtLoad <= 1'b0;
            // The filter sum settles on the load cycle, so the flag trails the load by one.
            r_resValid <= r_filtLoad && (r_fillCnt == FILL_W'(WINDOW_SIZE));
            case (r_state)
                S_IDLE: begin
                    if (w_arbValid) begin
                        r_grant   <= w_arbGrant;
                        r_ownerId <= w_arbIdx;
                        r_resId   <= w_arbIdx;
                        r_filtClr <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_fillCnt <= '0;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_filtData <= w_ownerData;
                        r_filtLoad <= 1'b1;
                        if (r_fillCnt != FILL_W'(WINDOW_SIZE)) begin
                            r_fillCnt <= r_fillCnt + FILL_W'(1);
                        end
                    end
                    if (w_exit) begin
                        r_drainLast <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drainLast) begin
                        r_rrPtr <= ID_W'((int'(r_ownerId) + 1) % NUM_REQ);
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_drainLast <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_filt_clr  = r_filtClr;
    assign o_filt_load = r_filtLoad;
    assign o_filt_data = r_filtData;
    assign o_res_valid = r_resValid;
    assign o_res_id    = r_resId;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ma_burst_scheduler.sv
// Directed self-checking bench for ma_burst_scheduler (4 requesters, 6-bit samples).
// The timeout scenario adapts its expectations to MA_SCHED_TIMEOUT_EN.
module tb_ma_burst_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int SAMPLE_W = 6;

`ifdef MA_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          inValid;
    logic [NUM_REQ-1:0]          inLast;
    logic [NUM_REQ*SAMPLE_W-1:0] inData;
    logic [NUM_REQ-1:0]          inReady;
    logic [NUM_REQ-1:0]          grant;
    logic                        filtClr;
    logic                        filtLoad;
    logic [SAMPLE_W-1:0]         filtData;
    logic                        resValid;
    logic [1:0]                  resId;
    logic                        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ma_burst_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .SAMPLE_W    (SAMPLE_W),
        .WINDOW_SIZE (4),
        .MAX_BURST   (16)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_in_valid  (inValid),
        .i_in_last   (inLast),
        .i_in_data   (inData),
        .o_in_ready  (inReady),
        .o_grant     (grant),
        .o_filt_clr  (filtClr),
        .o_filt_load (filtLoad),
        .o_filt_data (filtData),
        .o_res_valid (resValid),
        .o_res_id    (resId),
        .o_busy      (busy)
    );

    function automatic logic [23:0] lanes(input logic [5:0] a0, input logic [5:0] a1,
                                          input logic [5:0] a2, input logic [5:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] v,
                                 input logic [3:0] l, input logic [23:0] d);
        req     = r;
        inValid = v;
        inLast  = l;
        inData  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 24'h0);
        tick();
        tick();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_ready", inReady, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_clr", filtClr, 0);
        checkOutput("rst_load", filtLoad, 0);
        checkOutput("rst_data", filtData, 0);
        checkOutput("rst_rv", resValid, 0);
        checkOutput("rst_id", resId, 0);

        // Single requester 1: six samples, last on the sixth.
        reset = 1'b0;
        applyStimulus(4'b0010, 4'b0010, 4'b0000, lanes(6'h3F, 6'h01, 6'h3E, 6'h3D));
        tick();
        checkOutput("s1_grant", grant, 4'b0010);
        checkOutput("s1_clr", filtClr, 1);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_ready0", inReady, 0);
        checkOutput("s1_id", resId, 1);
        tick();
        checkOutput("s1_clr_once", filtClr, 0);
        checkOutput("s1_ready", inReady, 4'b0010);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(4'b0010, 4'b0010, (k == 6) ? 4'b0010 : 4'b0000,
                          lanes(6'h3F, 6'(k), 6'h3E, 6'h3D));
            tick();
            checkOutput($sformatf("s1_load%0d", k), filtLoad, 1);
            checkOutput($sformatf("s1_data%0d", k), filtData, k);
            checkOutput($sformatf("s1_rdy%0d", k), inReady, (k == 6) ? 0 : 4'b0010);
            checkOutput($sformatf("s1_rv%0d", k), resValid, (k >= 5) ? 1 : 0);
            checkOutput($sformatf("s1_rid%0d", k), resId, 1);
            checkOutput($sformatf("s1_clr%0d", k), filtClr, 0);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 24'h0);
        tick();
        checkOutput("s1_d2_load", filtLoad, 0);
        checkOutput("s1_d2_rv", resValid, 1);
        checkOutput("s1_d2_busy", busy, 1);
        checkOutput("s1_d2_data", filtData, 6);
        tick();
        checkOutput("s1_idle_busy", busy, 0);
        checkOutput("s1_idle_grant", grant, 0);
        checkOutput("s1_idle_rv", resValid, 0);
        checkOutput("s1_idle_id", resId, 1);

        // Early drop: requester 2 drops req together with its second sample.
        applyStimulus(4'b0100, 4'b0100, 4'b0000, lanes(6'h01, 6'h02, 6'h0A, 6'h04));
        tick();
        checkOutput("ed_grant", grant, 4'b0100);
        checkOutput("ed_clr", filtClr, 1);
        checkOutput("ed_id", resId, 2);
        tick();
        checkOutput("ed_ready", inReady, 4'b0100);
        tick();
        checkOutput("ed_load1", filtLoad, 1);
        checkOutput("ed_data1", filtData, 6'h0A);
        applyStimulus(4'b0000, 4'b0100, 4'b0000, lanes(6'h01, 6'h02, 6'h0B, 6'h04));
        tick();
        checkOutput("ed_load2", filtLoad, 1);
        checkOutput("ed_data2", filtData, 6'h0B);
        checkOutput("ed_drain_rdy", inReady, 0);
        checkOutput("ed_drain_busy", busy, 1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 24'h0);
        tick();
        checkOutput("ed_d2_load", filtLoad, 0);
        checkOutput("ed_d2_rv", resValid, 0);
        tick();
        checkOutput("ed_idle_busy", busy, 0);
        checkOutput("ed_idle_rv", resValid, 0);

        // All requesting: pointer left at 3 by the early drop, then reset mid-stream.
        applyStimulus(4'b1111, 4'b1111, 4'b0000, lanes(6'h31, 6'h32, 6'h33, 6'h21));
        tick();
        checkOutput("ptr3_grant", grant, 4'b1000);
        checkOutput("ptr3_id", resId, 3);
        checkOutput("ptr3_clr", filtClr, 1);
        tick();
        checkOutput("ptr3_ready", inReady, 4'b1000);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(4'b1111, 4'b1111, 4'b0000, lanes(6'h31, 6'h32, 6'h33, 6'(32 + k)));
            tick();
            checkOutput($sformatf("ptr3_data%0d", k), filtData, 32 + k);
        end
        reset = 1'b1;
        tick();
        checkOutput("mr_grant", grant, 0);
        checkOutput("mr_ready", inReady, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_clr", filtClr, 0);
        checkOutput("mr_load", filtLoad, 0);
        checkOutput("mr_data", filtData, 0);
        checkOutput("mr_rv", resValid, 0);
        checkOutput("mr_id", resId, 0);
        reset = 1'b0;
        applyStimulus(4'b0001, 4'b0000, 4'b0000, lanes(6'h31, 6'h32, 6'h33, 6'h34));
        tick();
        checkOutput("mr_regrant", grant, 4'b0001);
        checkOutput("mr_reclr", filtClr, 1);
        checkOutput("mr_rebusy", busy, 1);

        // Round-robin: four samples per burst, expected owners 0,1,2,3,0.
        applyStimulus(4'b1111, 4'b1111, 4'b0000, lanes(6'h01, 6'h09, 6'h11, 6'h19));
        for (int b = 0; b < 5; b++) begin
            oh = 4'b0001 << (b % 4);
            if (b > 0) begin
                tick();
                checkOutput($sformatf("rr%0d_grant", b), grant, oh);
                checkOutput($sformatf("rr%0d_clr", b), filtClr, 1);
                checkOutput($sformatf("rr%0d_id", b), resId, b % 4);
            end
            tick();
            checkOutput($sformatf("rr%0d_ready", b), inReady, oh);
            for (int k = 0; k < 4; k++) begin
                applyStimulus(4'b1111, 4'b1111, (k == 3) ? 4'b1111 : 4'b0000,
                              lanes(6'(k + 1), 6'(9 + k), 6'(17 + k), 6'(25 + k)));
                tick();
                checkOutput($sformatf("rr%0d_load%0d", b, k), filtLoad, 1);
                checkOutput($sformatf("rr%0d_data%0d", b, k), filtData, (b % 4) * 8 + k + 1);
                checkOutput($sformatf("rr%0d_rdy%0d", b, k), inReady, (k == 3) ? 4'b0000 : oh);
            end
            applyStimulus((b == 4) ? 4'b0000 : 4'b1111, 4'b1111, 4'b0000,
                          lanes(6'h01, 6'h09, 6'h11, 6'h19));
            tick();
            checkOutput($sformatf("rr%0d_rv", b), resValid, 1);
            checkOutput($sformatf("rr%0d_rvid", b), resId, b % 4);
            tick();
            checkOutput($sformatf("rr%0d_idle", b), busy, 0);
            checkOutput($sformatf("rr%0d_idlegrant", b), grant, 0);
        end

        // Backpressure on requester 1: valid toggles, only handshakes fill the window.
        applyStimulus(4'b0010, 4'b0000, 4'b0000, lanes(6'h3F, 6'h10, 6'h3E, 6'h3D));
        tick();
        checkOutput("bp_grant", grant, 4'b0010);
        checkOutput("bp_clr", filtClr, 1);
        tick();
        checkOutput("bp_ready", inReady, 4'b0010);
        for (int s = 0; s <= 6; s++) begin
            applyStimulus(4'b0010, (s % 2 == 0) ? 4'b0010 : 4'b0000,
                          (s == 6) ? 4'b0010 : 4'b0000, lanes(6'h3F, 6'(16 + s), 6'h3E, 6'h3D));
            tick();
            checkOutput($sformatf("bp_load%0d", s), filtLoad, (s % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("bp_data%0d", s), filtData, 16 + (s - (s % 2)));
            checkOutput($sformatf("bp_rv%0d", s), resValid, 0);
            checkOutput($sformatf("bp_rdy%0d", s), inReady, (s == 6) ? 4'b0000 : 4'b0010);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 24'h0);
        tick();
        checkOutput("bp_rv_full", resValid, 1);
        checkOutput("bp_rv_id", resId, 1);
        tick();
        checkOutput("bp_idle", busy, 0);

        // Continuous streaming from requesters 0 and 3, pointer reset to 0 first.
        reset = 1'b1;
        tick();
        checkOutput("to_rst_busy", busy, 0);
        reset = 1'b0;
        applyStimulus(4'b1001, 4'b1001, 4'b0000, lanes(6'h00, 6'h3F, 6'h3F, 6'h2A));
        tick();
        checkOutput("to_grant0", grant, 4'b0001);
        tick();
        checkOutput("to_ready0", inReady, 4'b0001);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(4'b1001, 4'b1001, 4'b0000, lanes(6'(k), 6'h3F, 6'h3F, 6'h2A));
            tick();
            if (k == 16) begin
                checkOutput("to_load16", filtLoad, 1);
                checkOutput("to_data16", filtData, 16);
                checkOutput("to_rdy16", inReady, TIMEOUT_ON ? 4'b0000 : 4'b0001);
            end
        end
        tick();
        checkOutput("to_rv", resValid, 1);
        tick();
        tick();
        checkOutput("to_next_grant", grant, TIMEOUT_ON ? 4'b1000 : 4'b0001);
        checkOutput("to_next_id", resId, TIMEOUT_ON ? 3 : 0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 24'h0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
